// File: rtl/qspis_pkg.sv
// qspis_pkg: shared types and constants for the SPI-slave AXI-to-OBI bridge.
//   state_e           - bridge FSM states
//   Resp*/Burst*      - AXI response and burst encodings
//   burst_unsupported - flags bursts that must be answered without touching OBI
package qspis_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StWrReq,
    StWrRsp,
    StWrB,
    StRdReq,
    StRdRsp,
    StRdData
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;

  // WRAP, reserved burst types and beats wider than the 32-bit bus are not served.
  function automatic logic burst_unsupported(input logic [1:0] burst, input logic [2:0] size);
    return !((burst == BurstFixed) || (burst == BurstIncr)) || (size > 3'd2);
  endfunction

endpackage

// File: rtl/spis_axi2obi_addr_gen.sv
// spis_axi2obi_addr_gen: beat address and beat counter for one AXI burst.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : latch a new burst (addr/len/size/burst), beat counter to 0
//   step_i       : advance to the next beat
//   addr_o       : current (unaligned) beat address
//   last_o       : current beat is the final one (beat == len)
module spis_axi2obi_addr_gen
  import qspis_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            beat_q, beat_d;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;

  always_comb begin
    addr_d = addr_q;
    beat_d = beat_q;
    if (load_i) begin
      addr_d = addr_i;
      beat_d = '0;
    end else if (step_i) begin
      beat_d = beat_q + 8'd1;
      // FIXED bursts keep hitting the same address.
      if (burst_q == BurstIncr) begin
        addr_d = addr_q + (ADDR_WIDTH'(1) << size_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else begin
      addr_q <= addr_d;
      beat_q <= beat_d;
      if (load_i) begin
        len_q   <= len_i;
        size_q  <= size_i;
        burst_q <= burst_i;
      end
    end
  end

  assign addr_o = addr_q;
  assign last_o = (beat_q == len_q);

endmodule

// File: rtl/spis_axi2obi.sv
// spis_axi2obi: AXI slave (fed by the SPI-slave AXI master) driving the X-HEEP OBI bus.
// One burst at a time, one OBI transaction per beat.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   aw_* / w_* / b_*     : AXI write address, data and response channels
//   ar_* / r_*           : AXI read address and data channels
//   req_o..err_i         : OBI master port (32-bit data)
module spis_axi2obi
  import qspis_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [ADDR_WIDTH-1:0] aw_addr_i,
  input  logic [7:0]            aw_len_i,
  input  logic [2:0]            aw_size_i,
  input  logic [1:0]            aw_burst_i,
  input  logic [ID_WIDTH-1:0]   aw_id_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic [31:0]           w_data_i,
  input  logic [3:0]            w_strb_i,
  input  logic                  w_last_i,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [1:0]            b_resp_o,
  output logic [ID_WIDTH-1:0]   b_id_o,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]            ar_len_i,
  input  logic [2:0]            ar_size_i,
  input  logic [1:0]            ar_burst_i,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [31:0]           r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  we_o,
  output logic [3:0]            be_o,
  output logic [31:0]           wdata_o,
  input  logic                  rvalid_i,
  input  logic [31:0]           rdata_i,
  input  logic                  err_i
);

  state_e                state_q, state_d;
  logic                  prio_q;   // 1: read wins the next AW/AR collision
  logic [ID_WIDTH-1:0]   id_q;
  logic                  err_q;    // sticky burst error, drives b_resp_o
  logic                  bad_q;    // unsupported burst: no OBI traffic
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;

  logic                  aw_hs, ar_hs, w_hs, load, step, last;
  logic [ADDR_WIDTH-1:0] beat_addr, obi_addr, ld_addr;
  logic [7:0]            ld_len;
  logic [2:0]            ld_size;
  logic [1:0]            ld_burst;
  logic                  ld_bad;

  assign aw_hs    = aw_valid_i & aw_ready_o;
  assign ar_hs    = ar_valid_i & ar_ready_o;
  assign w_hs     = w_valid_i & w_ready_o;
  assign load     = aw_hs | ar_hs;
  assign ld_addr  = aw_hs ? aw_addr_i : ar_addr_i;
  assign ld_len   = aw_hs ? aw_len_i : ar_len_i;
  assign ld_size  = aw_hs ? aw_size_i : ar_size_i;
  assign ld_burst = aw_hs ? aw_burst_i : ar_burst_i;
  assign ld_bad   = burst_unsupported(ld_burst, ld_size);
  assign obi_addr = beat_addr & ~(ADDR_WIDTH'(3));

  // Advance only while beats remain; the counter alone decides where a burst ends.
  assign step = !last & (((state_q == StWrData) & w_hs & bad_q) |
                         ((state_q == StWrRsp) & rvalid_i) |
                         ((state_q == StRdData) & r_ready_i));

  spis_axi2obi_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .step_i (step),
    .addr_i (ld_addr),
    .len_i  (ld_len),
    .size_i (ld_size),
    .burst_i(ld_burst),
    .addr_o (beat_addr),
    .last_o (last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (aw_hs)      state_d = StWrData;
        else if (ar_hs) state_d = ld_bad ? StRdData : StRdReq;
      end
      StWrData: begin
        if (w_valid_i) begin
          if (!bad_q)    state_d = StWrReq;
          else if (last) state_d = StWrB;
        end
      end
      StWrReq:  if (gnt_i) state_d = StWrRsp;
      StWrRsp:  if (rvalid_i) state_d = last ? StWrB : StWrData;
      StWrB:    if (b_ready_i) state_d = StIdle;
      StRdReq:  if (gnt_i) state_d = StRdRsp;
      StRdRsp:  if (rvalid_i) state_d = StRdData;
      StRdData: begin
        if (r_ready_i) begin
          if (last)       state_d = StIdle;
          else if (bad_q) state_d = StRdData;
          else            state_d = StRdReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    aw_ready_o = 1'b0;
    ar_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    b_resp_o   = RespOkay;
    b_id_o     = id_q;
    r_valid_o  = 1'b0;
    r_data_o   = rdata_q;
    r_resp_o   = RespOkay;
    r_last_o   = 1'b0;
    r_id_o     = id_q;
    req_o      = 1'b0;
    we_o       = 1'b0;
    be_o       = 4'h0;
    addr_o     = '0;
    wdata_o    = '0;
    unique case (state_q)
      StIdle: begin
        aw_ready_o = aw_valid_i & (~ar_valid_i | ~prio_q);
        ar_ready_o = ar_valid_i & (~aw_valid_i | prio_q);
      end
      StWrData: w_ready_o = 1'b1;
      StWrReq: begin
        req_o   = 1'b1;
        we_o    = 1'b1;
        be_o    = wstrb_q;
        addr_o  = obi_addr;
        wdata_o = wdata_q;
      end
      StWrB: begin
        b_valid_o = 1'b1;
        b_resp_o  = err_q ? RespSlvErr : RespOkay;
      end
      StRdReq: begin
        req_o  = 1'b1;
        be_o   = 4'hF;
        addr_o = obi_addr;
      end
      StRdData: begin
        r_valid_o = 1'b1;
        r_resp_o  = rresp_q;
        r_last_o  = last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q  <= 1'b0;
      id_q    <= '0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      rresp_q <= RespOkay;
    end else begin
      if (load) begin
        prio_q <= ~prio_q;
        id_q   <= aw_hs ? aw_id_i : ar_id_i;
        bad_q  <= ld_bad;
        err_q  <= ld_bad;
      end
      // Unsupported reads return zero data with SLVERR on every beat.
      if (ar_hs) begin
        rdata_q <= '0;
        rresp_q <= ld_bad ? RespSlvErr : RespOkay;
      end
      if (w_hs) begin
        wdata_q <= w_data_i;
        wstrb_q <= w_strb_i;
        if (w_last_i != last) err_q <= 1'b1;
      end
      if ((state_q == StWrRsp) && rvalid_i && err_i) err_q <= 1'b1;
      if ((state_q == StRdRsp) && rvalid_i) begin
        rdata_q <= rdata_i;
        rresp_q <= err_i ? RespSlvErr : RespOkay;
      end
    end
  end

endmodule

// File: tb/tb_spis_axi2obi.sv
// tb_spis_axi2obi: randomized scoreboard bench for spis_axi2obi.
module tb_spis_axi2obi;
  localparam int unsigned IW = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic aw_valid_i = 0, aw_ready_o;
  logic [31:0] aw_addr_i = 0;
  logic [7:0] aw_len_i = 0;
  logic [2:0] aw_size_i = 0;
  logic [1:0] aw_burst_i = 0;
  logic [IW-1:0] aw_id_i = 0;
  logic w_valid_i = 0, w_ready_o;
  logic [31:0] w_data_i = 0;
  logic [3:0] w_strb_i = 0;
  logic w_last_i = 0;
  logic b_valid_o, b_ready_i = 0;
  logic [1:0] b_resp_o;
  logic [IW-1:0] b_id_o;
  logic ar_valid_i = 0, ar_ready_o;
  logic [31:0] ar_addr_i = 0;
  logic [7:0] ar_len_i = 0;
  logic [2:0] ar_size_i = 0;
  logic [1:0] ar_burst_i = 0;
  logic [IW-1:0] ar_id_i = 0;
  logic r_valid_o, r_ready_i = 0;
  logic [31:0] r_data_o;
  logic [1:0] r_resp_o;
  logic r_last_o;
  logic [IW-1:0] r_id_o;
  logic req_o, gnt_i = 0, we_o, rvalid_i = 0, err_i = 0;
  logic [31:0] addr_o, wdata_o, rdata_i = 0;
  logic [3:0] be_o;

  always #5 clk_i = ~clk_i;

  spis_axi2obi #(.ADDR_WIDTH(32), .ID_WIDTH(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i), .aw_id_i(aw_id_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_resp_o(b_resp_o), .b_id_o(b_id_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i), .ar_id_i(ar_id_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_resp_o(r_resp_o),
    .r_last_o(r_last_o), .r_id_o(r_id_o),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o), .be_o(be_o),
    .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_t;
  typedef struct {
    logic [31:0]   data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
  } r_t;
  typedef struct {
    logic [1:0]    resp;
    logic [IW-1:0] id;
  } b_t;

  obi_t obi_q[$];
  r_t   r_q[$];
  b_t   b_q[$];
  int checks = 0;
  int errors = 0;
  int obi_cnt = 0;
  logic [31:0] err_addr = 32'hFFFF_FFF0;
  bit slave_en = 1'b1;
  bit force_rv = 1'b0;
  bit tb_prio = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // OBI slave: random grant delay, response 1..3 cycles after the grant.
  bit pend = 0, stall = 0;
  int dly = 0;
  logic [31:0] pend_addr;
  obi_t held, oe;
  initial forever begin
    @(negedge clk_i);
    gnt_i = 0; rvalid_i = 0; err_i = 0; rdata_i = 32'h0;
    if (rst_i) begin
      pend = 0; stall = 0;
    end else if (!slave_en) begin
      rvalid_i = force_rv; err_i = force_rv; rdata_i = 32'hBAD0_BAD0; stall = 0;
    end else if (pend) begin
      dly--;
      if (dly == 0) begin
        rvalid_i = 1; rdata_i = rd_fn(pend_addr); err_i = (pend_addr == err_addr); pend = 0;
      end
    end else if (req_o) begin
      if (stall) begin
        chk("obi_hold_addr", addr_o, held.addr);
        chk("obi_hold_we", we_o, held.we);
        chk("obi_hold_be", be_o, held.be);
        chk("obi_hold_wdata", wdata_o, held.wdata);
      end
      if ($urandom_range(0, 2) != 0) begin
        gnt_i = 1; stall = 0; obi_cnt++;
        checks++;
        if (obi_q.size() == 0) begin
          errors++;
          $display("FAIL obi_unexpected: got req addr %0h, expected no request", addr_o);
        end else begin
          checks--;
          oe = obi_q.pop_front();
          chk("obi_addr", addr_o, oe.addr);
          chk("obi_we", we_o, oe.we);
          chk("obi_be", be_o, oe.be);
          if (oe.we) chk("obi_wdata", wdata_o, oe.wdata);
        end
        pend = 1; pend_addr = addr_o; dly = $urandom_range(1, 3);
      end else begin
        stall = 1; held = '{addr_o, we_o, be_o, wdata_o};
      end
    end
  end

  // R channel monitor with random back-pressure.
  bit r_stall = 0;
  logic [31:0] r_held;
  logic r_held_last;
  r_t re;
  initial forever begin
    @(negedge clk_i);
    r_ready_i = 0;
    if (rst_i) r_stall = 0;
    else if (r_valid_o) begin
      if (r_stall) begin
        chk("r_hold_data", r_data_o, r_held);
        chk("r_hold_last", r_last_o, r_held_last);
      end
      if ($urandom_range(0, 2) != 0) begin
        r_ready_i = 1; r_stall = 0;
        checks++;
        if (r_q.size() == 0) begin
          errors++;
          $display("FAIL r_unexpected: got data %0h, expected no beat", r_data_o);
        end else begin
          checks--;
          re = r_q.pop_front();
          chk("r_data", r_data_o, re.data);
          chk("r_resp", r_resp_o, re.resp);
          chk("r_last", r_last_o, re.last);
          chk("r_id", r_id_o, re.id);
        end
      end else begin
        r_stall = 1; r_held = r_data_o; r_held_last = r_last_o;
      end
    end
  end

  // B channel monitor.
  b_t be_exp;
  initial forever begin
    @(negedge clk_i);
    b_ready_i = 0;
    if (!rst_i && b_valid_o && ($urandom_range(0, 1) != 0)) begin
      b_ready_i = 1;
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got resp %0h, expected no response", b_resp_o);
      end else begin
        checks--;
        be_exp = b_q.pop_front();
        chk("b_resp", b_resp_o, be_exp.resp);
        chk("b_id", b_id_o, be_exp.id);
      end
    end
  end

  // Arbitration model: write first after reset, preference flips on every accepted burst.
  initial forever begin
    @(negedge clk_i);
    #1;
    if (rst_i) tb_prio = 0;
    else begin
      if (aw_valid_i && ar_valid_i) begin
        chk("arb_both_ready", aw_ready_o && ar_ready_o, 0);
        if (aw_ready_o || ar_ready_o) chk("arb_winner_is_read", ar_ready_o, tb_prio);
      end
      if ((aw_valid_i && aw_ready_o) || (ar_valid_i && ar_ready_o)) tb_prio = ~tb_prio;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic bit is_bad(input logic [1:0] burst, input logic [2:0] size);
    return !(burst == 2'b00 || burst == 2'b01) || size > 3'd2;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] burst,
                                            input logic [2:0] size, input int i);
    logic [31:0] a;
    a = base + ((burst == 2'b01) ? (32'(i) << size) : 32'd0);
    a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [IW-1:0] id,
                          input logic [31:0] d0, input logic [3:0] s0, input bit bad_last);
    logic [31:0] d[$];
    logic [3:0] s[$];
    logic [31:0] a;
    bit bad, err;
    int n;
    bad = is_bad(burst, size);
    err = bad || bad_last;
    for (int i = 0; i <= int'(len); i++) begin
      d.push_back(i == 0 ? d0 : $urandom);
      s.push_back(i == 0 ? s0 : 4'($urandom));
    end
    @(negedge clk_i);
    aw_valid_i = 1; aw_addr_i = addr; aw_len_i = len; aw_size_i = size;
    aw_burst_i = burst; aw_id_i = id;
    #1;
    n = 0;
    while (!aw_ready_o) begin
      @(negedge clk_i); #1; n++;
      if (n > 3000) begin
        chk("aw_ready_timeout", 0, 1); aw_valid_i = 0; return;
      end
    end
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, burst, size, i);
      if (!bad) begin
        obi_q.push_back('{a, 1'b1, s[i], d[i]});
        if (a == err_addr) err = 1;
      end
    end
    b_q.push_back('{err ? 2'b10 : 2'b00, id});
    @(negedge clk_i);
    aw_valid_i = 0;
    #1;
    chk("w_ready_after_aw", w_ready_o, 1);
    for (int i = 0; i <= int'(len); i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk_i);
      w_valid_i = 1; w_data_i = d[i]; w_strb_i = s[i];
      w_last_i = (i == int'(len)) ^ (bad_last && i == int'(len));
      #1;
      n = 0;
      while (!w_ready_o) begin
        @(negedge clk_i); #1; n++;
        if (n > 3000) begin
          chk("w_ready_timeout", 0, 1); w_valid_i = 0; return;
        end
      end
      @(negedge clk_i);
      w_valid_i = 0;
      #1;
      chk("req_after_w", req_o, !bad);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [IW-1:0] id);
    logic [31:0] a;
    bit bad;
    int n;
    bad = is_bad(burst, size);
    @(negedge clk_i);
    ar_valid_i = 1; ar_addr_i = addr; ar_len_i = len; ar_size_i = size;
    ar_burst_i = burst; ar_id_i = id;
    #1;
    n = 0;
    while (!ar_ready_o) begin
      @(negedge clk_i); #1; n++;
      if (n > 3000) begin
        chk("ar_ready_timeout", 0, 1); ar_valid_i = 0; return;
      end
    end
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, burst, size, i);
      if (bad) r_q.push_back('{32'h0, 2'b10, i == int'(len), id});
      else begin
        obi_q.push_back('{a, 1'b0, 4'hF, 32'h0});
        r_q.push_back('{rd_fn(a), (a == err_addr) ? 2'b10 : 2'b00, i == int'(len), id});
      end
    end
    @(negedge clk_i);
    ar_valid_i = 0;
    n = 0;
    while (r_q.size() != 0 && n < 3000) begin
      @(negedge clk_i); n++;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((obi_q.size() + r_q.size() + b_q.size()) != 0 && n < 5000) begin
      @(negedge clk_i); n++;
    end
    chk({name, "_drain_left"}, obi_q.size() + r_q.size() + b_q.size(), 0);
    obi_q.delete(); r_q.delete(); b_q.delete();
    repeat (2) @(negedge clk_i);
  endtask

  int base_cnt;

  initial begin
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_req", req_o, 0);
    chk("rst_aw_ready", aw_ready_o, 0);
    chk("rst_ar_ready", ar_ready_o, 0);
    chk("rst_w_ready", w_ready_o, 0);
    chk("rst_b_valid", b_valid_o, 0);
    chk("rst_r_valid", r_valid_o, 0);
    chk("rst_b_resp", b_resp_o, 0);
    chk("rst_r_resp", r_resp_o, 0);
    chk("rst_r_data", r_data_o, 0);
    chk("rst_obi_addr", addr_o, 0);
    chk("rst_obi_be", be_o, 0);
    rst_i = 0;

    do_write(32'h1000_0004, 8'd0, 3'd2, 2'b01, 3'd3, 32'hDEAD_BEEF, 4'h3, 0);
    drain("single_write");

    do_read(32'h0000_0100, 8'd3, 3'd2, 2'b01, 3'd6);
    drain("incr_read");

    fork
      begin
        do_write(32'h0000_0200, 8'd1, 3'd2, 2'b01, 3'd1, 32'h1111_1111, 4'hF, 0);
        do_write(32'h0000_0300, 8'd0, 3'd2, 2'b01, 3'd2, 32'h2222_2222, 4'hC, 0);
      end
      begin
        do_read(32'h0000_0240, 8'd1, 3'd2, 2'b01, 3'd4);
        do_read(32'h0000_0340, 8'd0, 3'd2, 2'b01, 3'd5);
      end
    join
    drain("collision");

    err_addr = 32'h0000_2004;
    base_cnt = obi_cnt;
    do_write(32'h0000_2000, 8'd3, 3'd2, 2'b01, 3'd1, 32'hCAFE_0000, 4'hF, 0);
    drain("err_write");
    chk("err_write_obi_count", obi_cnt - base_cnt, 4);
    err_addr = 32'hFFFF_FFF0;

    base_cnt = obi_cnt;
    do_read(32'h0000_0500, 8'd1, 3'd2, 2'b10, 3'd7);
    drain("wrap_read");
    chk("wrap_read_no_req", obi_cnt - base_cnt, 0);

    do_write(32'h0000_0400, 8'd2, 3'd2, 2'b00, 3'd2, 32'h0BAD_1A57, 4'hF, 1);
    drain("fixed_bad_last");
    do_write(32'h0000_0600, 8'd1, 3'd3, 2'b01, 3'd0, 32'h0, 4'hF, 0);
    drain("bad_size_write");

    // Reset while a read request waits for its grant.
    slave_en = 0;
    @(negedge clk_i);
    ar_valid_i = 1; ar_addr_i = 32'h0000_0700; ar_len_i = 0; ar_size_i = 2;
    ar_burst_i = 2'b01; ar_id_i = 3'd5;
    @(negedge clk_i);
    ar_valid_i = 0;
    #1;
    chk("pending_req", req_o, 1);
    @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    #1;
    chk("rst_mid_req", req_o, 0);
    chk("rst_mid_r_valid", r_valid_o, 0);
    rst_i = 0;
    force_rv = 1;
    @(negedge clk_i);
    #1;
    force_rv = 0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("late_rvalid_r_valid", r_valid_o, 0);
    chk("late_rvalid_b_valid", b_valid_o, 0);
    chk("late_rvalid_w_ready", w_ready_o, 0);
    chk("late_rvalid_req", req_o, 0);
    slave_en = 1;
    do_read(32'h0000_0800, 8'd1, 3'd2, 2'b01, 3'd3);
    drain("after_reset_read");
    do_write(32'h0000_0900, 8'd0, 3'd2, 2'b01, 3'd6, 32'h1234_5678, 4'h9, 0);
    drain("after_reset_write");

    for (int it = 0; it < 24; it++) begin
      logic [31:0] ra;
      logic [7:0] rl;
      logic [2:0] rs;
      logic [1:0] rb;
      int pick;
      ra = 32'h0001_0000 + (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(0, 3));
      rl = 8'($urandom_range(0, 3));
      rs = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      pick = $urandom_range(0, 9);
      rb = (pick < 6) ? 2'b01 : (pick < 8) ? 2'b00 : 2'($urandom_range(2, 3));
      err_addr = ($urandom_range(0, 3) == 0) ? ((ra & ~32'h3) + 32'h4) : 32'hFFFF_FFF0;
      if ($urandom_range(0, 1) != 0)
        do_write(ra, rl, rs, rb, 3'($urandom), $urandom, 4'($urandom), $urandom_range(0, 5) == 0);
      else
        do_read(ra, rl, rs, rb, 3'($urandom));
      drain("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spis_axi2obi.md
SPIS_AXI2OBI -- requirements
Module: spis_axi2obi

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, AXI/OBI address width; ID_WIDTH, default 3, AXI ID width. Data width SHALL be fixed at 32 bits.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have clk_i, input, 1 bit: clock.
REQ-004 SHALL have rst_i, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have an AW channel: aw_valid_i in 1; aw_ready_o out 1; aw_addr_i in ADDR_WIDTH; aw_len_i in 8; aw_size_i in 3; aw_burst_i in 2; aw_id_i in ID_WIDTH.
REQ-006 SHALL have a W channel: w_valid_i in 1; w_ready_o out 1; w_data_i in 32; w_strb_i in 4; w_last_i in 1.
REQ-007 SHALL have a B channel: b_valid_o out 1; b_ready_i in 1; b_resp_o out 2; b_id_o out ID_WIDTH.
REQ-008 SHALL have an AR channel: ar_valid_i in 1; ar_ready_o out 1; ar_addr_i in ADDR_WIDTH; ar_len_i in 8; ar_size_i in 3; ar_burst_i in 2; ar_id_i in ID_WIDTH.
REQ-009 SHALL have an R channel: r_valid_o out 1; r_ready_i in 1; r_data_o out 32; r_resp_o out 2; r_last_o out 1; r_id_o out ID_WIDTH.
REQ-010 SHALL have an OBI master port: req_o out 1; gnt_i in 1; addr_o out ADDR_WIDTH; we_o out 1; be_o out 4; wdata_o out 32; rvalid_i in 1; rdata_i in 32; err_i in 1. Function: the block is the AXI slave fed by the SPI-slave AXI master; it drives the X-HEEP OBI bus.

Function
REQ-011 SHALL implement FSM states IDLE, WR_DATA, WR_REQ, WR_RSP, WR_B, RD_REQ, RD_RSP and RD_DATA.
REQ-012 SHALL assert aw_ready_o and ar_ready_o only in IDLE; a handshake latches addr, len, size, burst and id and clears the beat counter and error flag.
REQ-013 SHALL arbitrate simultaneous aw_valid_i/ar_valid_i with a priority bit (reset: write first) that toggles after each accepted burst; only one ready is asserted per cycle.
REQ-014 SHALL, for writes, assert w_ready_o in WR_DATA only; a W handshake latches data/strb and moves to WR_REQ.
REQ-015 SHALL, in WR_REQ/RD_REQ, hold req_o=1 with addr_o, we_o, be_o and wdata_o stable until gnt_i, then move to WR_RSP/RD_RSP.
REQ-016 SHALL drive addr_o as the beat address with bits [1:0] forced to 0. For reads, be_o SHALL be 4'hF.
REQ-017 SHALL, on rvalid_i in WR_RSP, go to WR_B if beat==len, else increment beat and address and return to WR_DATA.
REQ-018 SHALL, on rvalid_i in RD_RSP, register rdata_i into r_data_o and go to RD_DATA.
REQ-019 SHALL, in RD_DATA, hold r_valid_o until r_ready_i; r_last_o=(beat==len); then go to IDLE if last, else RD_REQ.
REQ-020 SHALL, in WR_B, hold b_valid_o with b_id_o until b_ready_i, then go to IDLE.
REQ-021 SHALL advance the address by 1<<size for INCR bursts and keep it unchanged for FIXED bursts; 4 KB boundary crossing is not checked.
REQ-022 SHALL treat burst WRAP/reserved or size>2 as an error burst: no OBI access; writes consume all len+1 beats; reads return len+1 beats with data 0; response SLVERR (2'b10).
REQ-023 SHALL make err_i on any rvalid_i sticky for the burst, giving b_resp_o=SLVERR; r_resp_o SHALL be per beat.
REQ-024 SHALL set the error flag when w_last_i does not equal (beat==len); the beat count governs burst end.
REQ-025 SHALL ignore rvalid_i received outside WR_RSP/RD_RSP.
REQ-026 SHALL have a minimum single-beat write latency of: AW hs cycle N, w_ready_o N+1, req_o the cycle after W hs, b_valid_o the cycle after rvalid_i.

Reset
REQ-027 SHALL, on rst_i, go to IDLE with all outputs 0 (b_resp_o/r_resp_o=OKAY), counters 0, priority=write, error flag 0, including mid-burst and while req_o is pending.

Structure
REQ-028 SHALL place the FSM state enum, resp codes (OKAY 2'b00, SLVERR 2'b10) and burst codes (FIXED 2'b00, INCR 2'b01) in qspis_pkg.
REQ-029 SHALL implement beat address and counter generation in one sub-module, spis_axi2obi_addr_gen.

Verification
REQ-030 SHALL verify: single write, addr 0x1000_0004, strb 4'h3, data 0xDEADBEEF -> one OBI req with addr 0x1000_0004, be 4'h3, we=1; b_resp OKAY; b_id echoed.
REQ-031 SHALL verify: INCR read, len 3, size 2, addr 0x100 -> OBI addresses 0x100, 0x104, 0x108, 0x10C; 4 R beats; r_last only on the 4th; r_ready stalls hold data stable.
REQ-032 SHALL verify: AW and AR valid in the same cycle, twice -> write served first, then read, then write; never both readies at once.
REQ-033 SHALL verify: err_i on beat 2 of a 4-beat write -> all 4 OBI writes issued; b_resp SLVERR.
REQ-034 SHALL verify: WRAP read, len 1 -> no req_o; 2 beats of data 0 with SLVERR and r_last on the 2nd.
REQ-035 SHALL verify: rst_i asserted while req_o is pending without gnt_i -> next cycle req_o=0 in IDLE; a late rvalid_i is ignored; a new burst completes normally.
